// File: rtl/data_mem_bytectl.sv
// Byte-addressable 32-bit data memory with a request/response handshake,
// programmable wait states, and sub-word load extension and store merging.
module data_mem_bytectl #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  o_dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS] = '{default: 32'h0};

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_we;
    logic [1:0]       w_size;
    logic             w_uns;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic [1:0]       w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_err;
    logic [3:0]       w_be;
    logic [31:0]      w_wlane;
    logic [31:0]      w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;

    assign w_accept = req_valid && (r_state == S_IDLE);
    // With zero wait states the access happens on the accept edge itself,
    // so the live request fields are used instead of the captured copies.
    assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                          ((r_state == S_WAIT) && (r_cnt == 4'd0));
    assign w_we    = (r_state == S_IDLE) ? req_we       : r_we;
    assign w_size  = (r_state == S_IDLE) ? req_size     : r_size;
    assign w_uns   = (r_state == S_IDLE) ? req_unsigned : r_uns;
    assign w_addr  = (r_state == S_IDLE) ? req_addr     : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? req_wdata    : r_wdata;

    assign w_off = w_addr[1:0];
    assign w_idx = w_addr[IDX_W+1:2];
    assign w_err = (w_size == 2'b11) ||
                   ((w_size == 2'b01) && w_off[0]) ||
                   ((w_size == 2'b10) && (w_off != 2'b00)) ||
                   (w_addr[31:IDX_W+2] != '0);

    always_comb begin
        w_be    = 4'b0000;
        w_wlane = w_wdata;
        case (w_size)
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wlane = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_off, 3'b000} +: 8];
    assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = w_word;
        case (w_size)
            2'b00:   w_load = w_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = w_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Memory is deliberately outside the reset domain; reset only blocks a commit.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp && w_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= CNT_LOAD;
                        r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_RESP: begin
                    if (resp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_we) ? 32'h0 : w_load;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign resp_valid  = (r_state == S_RESP);
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_bytectl.sv
// Directed bench for data_mem_bytectl: three instances cover WAIT_CYCLES of 1, 3 and 0.
module tb_data_mem_bytectl;

    logic        clk = 1'b0;
    logic        rst [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we [3];
    logic [1:0]  req_size [3];
    logic        req_unsigned [3];
    logic [31:0] req_addr [3];
    logic [31:0] req_wdata [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err [3];
    logic [1:0]  dbg_state [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_bytectl #(.DEPTH_WORDS(4096), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .o_dbg_state(dbg_state[0]));

    data_mem_bytectl #(.DEPTH_WORDS(4096), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .o_dbg_state(dbg_state[1]));

    data_mem_bytectl #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
        .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]),
        .o_dbg_state(dbg_state[2]));

    function automatic int wc(int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(int d, logic we, logic [1:0] size, logic uns,
                         logic [31:0] addr, logic [31:0] wdata);
        req_we[d]       = we;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
        req_valid[d]    = 1'b1;
        check("req_ready_before_accept", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    // lat counts edges after the accept edge until resp_valid is seen.
    task automatic wait_resp(int d, output int lat);
        lat = 0;
        while (!resp_valid[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid[d]) check("resp_timeout", 32'(resp_valid[d]), 32'd1);
    endtask

    task automatic do_req(int d, string tag, logic we, logic [1:0] size, logic uns,
                          logic [31:0] addr, logic [31:0] wdata,
                          logic [31:0] exp_rdata, logic exp_err);
        int lat;
        issue(d, we, size, uns, addr, wdata);
        wait_resp(d, lat);
        check({tag, "_lat"}, 32'(lat), 32'(wc(d)));
        check({tag, "_rdata"}, resp_rdata[d], exp_rdata);
        check({tag, "_err"}, 32'(resp_err[d]), 32'(exp_err));
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 32'(dbg_state[d]), 32'd0);
    endtask

    initial begin
        int lat;
        int acc;
        for (int d = 0; d < 3; d++) begin
            rst[d]          = 1'b1;
            req_valid[d]    = 1'b0;
            req_we[d]       = 1'b0;
            req_size[d]     = 2'b10;
            req_unsigned[d] = 1'b0;
            req_addr[d]     = 32'h0;
            req_wdata[d]    = 32'h0;
            resp_ready[d]   = 1'b1;
        end
        // A store presented during reset must be ignored.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_wdata[0] = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_rdata", resp_rdata[0], 32'h0);
        check("rst_err", 32'(resp_err[0]), 32'd0);
        req_valid[0] = 1'b0;
        req_we[0]    = 1'b0;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("post_rst_ready", 32'(req_ready[d]), 32'd1);
            check("post_rst_state", 32'(dbg_state[d]), 32'd0);
        end

        // WAIT_CYCLES=1: word and sub-word access
        do_req(0, "st_w",   1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        do_req(0, "ld_w",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        do_req(0, "st_b",   1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FF5A, 32'h0, 1'b0);
        do_req(0, "ld_w2",  1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hDEAD_5AEF, 1'b0);
        do_req(0, "ld_bs",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0);
        do_req(0, "ld_hu",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000_DEAD, 1'b0);
        do_req(0, "ld_hs",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0);
        do_req(0, "ld_bu",  1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h0000_00EF, 1'b0);
        do_req(0, "ld_bs1", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000_005A, 1'b0);
        do_req(0, "st_h",   1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD_1234, 32'h0, 1'b0);
        do_req(0, "ld_w3",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_5AEF, 1'b0);

        // Errors: misaligned, illegal size, out of range; none may touch memory.
        do_req(0, "err_h",   1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 32'h0, 1'b1);
        do_req(0, "err_w",   1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
        do_req(0, "err_sz",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        do_req(0, "err_oor", 1'b1, 2'b10, 1'b0, 32'h4000, 32'hCAFE_F00D, 32'h0, 1'b1);
        do_req(0, "ld_zero", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        do_req(0, "err_mis", 1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_req(0, "ld_keep", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_5AEF, 1'b0);

        // Backpressure: response must hold while resp_ready is low.
        resp_ready[0] = 1'b0;
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        wait_resp(0, lat);
        check("bp_lat", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(resp_valid[0]), 32'd1);
            check("bp_rdata", resp_rdata[0], 32'h1234_5AEF);
            check("bp_err", 32'(resp_err[0]), 32'd0);
            check("bp_ready", 32'(req_ready[0]), 32'd0);
            @(posedge clk);
            #1;
        end
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_state", 32'(dbg_state[0]), 32'd0);
        check("bp_release_ready", 32'(req_ready[0]), 32'd1);

        // WAIT_CYCLES=3: reset during WAIT drops the store.
        issue(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
        check("w3_in_wait", 32'(dbg_state[1]), 32'd1);
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        check("w3_rst_valid", 32'(resp_valid[1]), 32'd0);
        do_req(1, "w3_ld_dropped", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        do_req(1, "w3_st",  1'b1, 2'b10, 1'b0, 32'h24, 32'hA5A5_5A5A, 32'h0, 1'b0);
        do_req(1, "w3_ld",  1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'hA5A5_5A5A, 1'b0);

        // Reset during RESP drops the response but keeps the committed write.
        resp_ready[1] = 1'b0;
        issue(1, 1'b1, 2'b10, 1'b0, 32'h28, 32'h5566_7788);
        wait_resp(1, lat);
        check("w3_resp_lat", 32'(lat), 32'd3);
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        resp_ready[1] = 1'b1;
        check("w3_rst_resp_valid", 32'(resp_valid[1]), 32'd0);
        do_req(1, "w3_ld_kept", 1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 32'h5566_7788, 1'b0);

        // WAIT_CYCLES=0: single-cycle latency and accept every second cycle.
        do_req(2, "w0_st", 1'b1, 2'b10, 1'b0, 32'h8, 32'h0BAD_CAFE, 32'h0, 1'b0);
        do_req(2, "w0_ld", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0BAD_CAFE, 1'b0);
        do_req(2, "w0_err", 1'b0, 2'b01, 1'b0, 32'h9, 32'h0, 32'h0, 1'b1);
        acc = 0;
        req_we[2]    = 1'b0;
        req_size[2]  = 2'b10;
        req_addr[2]  = 32'h8;
        req_valid[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (req_ready[2]) acc++;
            if (resp_valid[2]) check("b2b_rdata", resp_rdata[2], 32'h0BAD_CAFE);
            check("b2b_alt", 32'(resp_valid[2]), 32'(i % 2));
            @(posedge clk);
            #1;
        end
        req_valid[2] = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
